// File: rtl/msrv32_dmem_pkg.sv
// msrv32 data-memory access controller: shared types.
// FSM state and access-size encodings.
package msrv32_dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/msrv32_store_align.sv
// msrv32 store alignment: byte strobes, lane-replicated data
// and misalignment detection from size and address LSBs.
module msrv32_store_align
  import msrv32_dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lsb,
  input  logic [31:0] i_rs2,
  output logic [3:0]  o_mask,
  output logic [31:0] o_data,
  output logic        o_misaligned
);

  // size 2'b11 falls through to the word case
  always_comb begin
    o_mask       = 4'b1111;
    o_data       = i_rs2;
    o_misaligned = (i_addr_lsb != 2'b00);
    case (i_size)
      SZ_BYTE: begin
        o_mask       = 4'b0001 << i_addr_lsb;
        o_data       = {4{i_rs2[7:0]}};
        o_misaligned = 1'b0;
      end
      SZ_HALF: begin
        o_mask       = 4'b0011 << {i_addr_lsb[1], 1'b0};
        o_data       = {2{i_rs2[15:0]}};
        o_misaligned = i_addr_lsb[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/msrv32_dmem_access_ctrl.sv
// msrv32 data-memory access controller: holds one bus
// transaction, stalls the pipeline, captures load data.
module msrv32_dmem_access_ctrl
  import msrv32_dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        mem_rd_req_in,
  input  logic        mem_wr_req_in,
  input  logic [31:0] iadder_in,
  input  logic [1:0]  access_size_in,
  input  logic [31:0] rs2_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic        ms_riscv32_mp_dmrd_req_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in,
  output logic [31:0] lu_data_out,
  output logic [1:0]  lu_addr_lsb_out,
  output logic        stall_out,
  output logic        done_out,
  output logic        misaligned_out,
  output logic        access_fault_out
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LIM_I =
    (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] LIM = LIM_I[CW-1:0];
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  logic        clk;
  logic        rst;
  state_e      r_state;
  state_e      w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr;
  logic [1:0]  r_lsb;
  logic [3:0]  r_mask;
  logic [31:0] r_data;
  logic        r_rd;
  logic        r_wr;
  logic        r_mis;
  logic        r_flt;
  logic [31:0] r_lu_data;
  logic [1:0]  r_lu_lsb;
  logic        w_req;
  logic        w_busy;
  logic        w_timeout;
  logic [3:0]  w_mask;
  logic [31:0] w_data;
  logic        w_mis;

  assign clk       = ms_riscv32_mp_clk_in;
  assign rst       = ms_riscv32_mp_rst_in;
  assign w_req     = mem_rd_req_in | mem_wr_req_in;
  assign w_busy    = (r_state == ST_BUSY);
  assign w_timeout = TO_EN && (r_cnt == LIM);

  msrv32_store_align u_align (
    .i_size       (access_size_in),
    .i_addr_lsb   (iadder_in[1:0]),
    .i_rs2        (rs2_in),
    .o_mask       (w_mask),
    .o_data       (w_data),
    .o_misaligned (w_mis)
  );

  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:
        if (w_req)
          w_next = w_mis ? ST_FAULT : ST_BUSY;
      ST_BUSY:
        if (ahb_ready_in)
          w_next = ahb_resp_in ? ST_FAULT : ST_DONE;
        else if (w_timeout)
          w_next = ST_FAULT;
      default:
        w_next = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // latch the bus transaction on accept; store beats load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_lsb  <= '0;
      r_mask <= '0;
      r_data <= '0;
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
    end else if (r_state == ST_IDLE && w_req && !w_mis) begin
      r_addr <= {iadder_in[31:2], 2'b00};
      r_lsb  <= iadder_in[1:0];
      r_mask <= mem_wr_req_in ? w_mask : 4'b0000;
      r_data <= mem_wr_req_in ? w_data : 32'h0;
      r_rd   <= ~mem_wr_req_in;
      r_wr   <= mem_wr_req_in;
    end
  end

  // wait-cycle counter, cleared on BUSY entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (r_state == ST_IDLE)
      r_cnt <= '0;
    else if (w_busy && !ahb_ready_in)
      r_cnt <= r_cnt + 1'b1;
  end

  // one-cycle flags, only ever high in FAULT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mis <= 1'b0;
      r_flt <= 1'b0;
    end else begin
      r_mis <= (r_state == ST_IDLE) && w_req && w_mis;
      r_flt <= w_busy &&
               (ahb_ready_in ? ahb_resp_in : w_timeout);
    end
  end

  // load-unit capture on a clean load completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lu_data <= '0;
      r_lu_lsb  <= '0;
    end else if (w_busy && ahb_ready_in && !ahb_resp_in && r_rd) begin
      r_lu_data <= ms_riscv32_mp_dmdata_in;
      r_lu_lsb  <= r_lsb;
    end
  end

  assign ms_riscv32_mp_dmaddr_out    = r_addr;
  assign ms_riscv32_mp_dmrd_req_out  = w_busy & r_rd;
  assign ms_riscv32_mp_dmwr_req_out  = w_busy & r_wr;
  assign ms_riscv32_mp_dmwr_mask_out = r_mask;
  assign ms_riscv32_mp_dmdata_out    = r_data;
  assign lu_data_out      = r_lu_data;
  assign lu_addr_lsb_out  = r_lu_lsb;
  assign stall_out        = ((r_state == ST_IDLE) & w_req) | w_busy;
  assign done_out         = (r_state == ST_DONE);
  assign misaligned_out   = r_mis;
  assign access_fault_out = r_flt;

endmodule

// File: tb/tb_msrv32_dmem_access_ctrl.sv
// msrv32 dmem access controller bench: directed cases then
// random transactions against a transaction-level model.
module tb_msrv32_dmem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [31:0] addr;
  logic [1:0]  sz;
  logic [31:0] rs2;
  logic [31:0] dmaddr;
  logic        dmrd, dmwr;
  logic [3:0]  mask;
  logic [31:0] dmdo;
  logic [31:0] dmdi;
  logic        ready, resp;
  logic [31:0] lu_data;
  logic [1:0]  lu_lsb;
  logic        stall, done, mis, flt;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_lu;
  logic [1:0]  exp_lsb;

  always #5 clk = ~clk;

  msrv32_dmem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_in        (rst),
    .mem_rd_req_in               (rd),
    .mem_wr_req_in               (wr),
    .iadder_in                   (addr),
    .access_size_in              (sz),
    .rs2_in                      (rs2),
    .ms_riscv32_mp_dmaddr_out    (dmaddr),
    .ms_riscv32_mp_dmrd_req_out  (dmrd),
    .ms_riscv32_mp_dmwr_req_out  (dmwr),
    .ms_riscv32_mp_dmwr_mask_out (mask),
    .ms_riscv32_mp_dmdata_out    (dmdo),
    .ms_riscv32_mp_dmdata_in     (dmdi),
    .ahb_ready_in                (ready),
    .ahb_resp_in                 (resp),
    .lu_data_out                 (lu_data),
    .lu_addr_lsb_out             (lu_lsb),
    .stall_out                   (stall),
    .done_out                    (done),
    .misaligned_out              (mis),
    .access_fault_out            (flt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_rq"}, {30'b0, dmrd, dmwr}, 32'd0);
    chk({tag, "_pulses"}, {29'b0, done, mis, flt}, 32'd0);
  endtask

  // one full transaction; waits = ready-low cycles in BUSY
  task automatic txn(input logic i_rd, input logic i_wr,
                     input logic [31:0] a, input logic [1:0] s,
                     input logic [31:0] d, input int waits,
                     input logic r_err, input logic [31:0] rdata);
    logic        st, misal, fault;
    logic [3:0]  em;
    logic [31:0] ed;
    st    = i_wr;
    misal = (s == 2'b01 && a[0]) || (s[1] && a[1:0] != 2'b00);
    case (s)
      2'b00: begin
        em = 4'(1 << a[1:0]);
        ed = {24'b0, d[7:0]} * 32'h0101_0101;
      end
      2'b01: begin
        em = 4'(3 << (a[1:0] & 2'b10));
        ed = {16'b0, d[15:0]} * 32'h0001_0001;
      end
      default: begin
        em = 4'hF;
        ed = d;
      end
    endcase
    if (!st) em = 4'h0;
    fault = r_err || (waits >= TO);

    @(posedge clk); #1;
    rd = i_rd; wr = i_wr; addr = a; sz = s; rs2 = d;
    ready = 1'($urandom); resp = 1'($urandom); dmdi = $urandom;
    @(negedge clk);
    chk("stall_c0", {31'b0, stall}, 32'd1);
    chk_idle_outs("c0");
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0; addr = $urandom; rs2 = $urandom;
    ready = 1'b0; resp = 1'b0;

    if (misal) begin
      @(negedge clk);
      chk("mis_pulse", {31'b0, mis}, 32'd1);
      chk("mis_stall", {31'b0, stall}, 32'd0);
      chk("mis_rq", {30'b0, dmrd, dmwr}, 32'd0);
      chk("mis_oth", {30'b0, done, flt}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_after", {31'b0, mis}, 32'd0);
      chk("mis_after_rq", {30'b0, dmrd, dmwr}, 32'd0);
      return;
    end

    for (int i = 0; i < TO; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == waits) begin
        ready = 1'b1; resp = r_err; dmdi = rdata;
      end else begin
        ready = 1'b0; resp = 1'($urandom); dmdi = $urandom;
      end
      @(negedge clk);
      chk("busy_stall", {31'b0, stall}, 32'd1);
      chk("busy_rd", {31'b0, dmrd}, {31'b0, ~st});
      chk("busy_wr", {31'b0, dmwr}, {31'b0, st});
      chk("busy_addr", dmaddr, {a[31:2], 2'b00});
      chk("busy_mask", {28'b0, mask}, {28'b0, em});
      if (st) chk("busy_data", dmdo, ed);
      chk("busy_pulses", {29'b0, done, mis, flt}, 32'd0);
      if (i == waits) break;
    end

    @(posedge clk); #1;
    ready = 1'($urandom); resp = 1'($urandom); dmdi = $urandom;
    if (!fault && !st) begin
      exp_lu  = rdata;
      exp_lsb = a[1:0];
    end
    @(negedge clk);
    chk("end_done", {31'b0, done}, {31'b0, ~fault});
    chk("end_fault", {31'b0, flt}, {31'b0, fault});
    chk("end_mis", {31'b0, mis}, 32'd0);
    chk("end_stall", {31'b0, stall}, 32'd0);
    chk("end_rq", {30'b0, dmrd, dmwr}, 32'd0);
    chk("lu_data", lu_data, exp_lu);
    chk("lu_lsb", {30'b0, lu_lsb}, {30'b0, exp_lsb});
    @(posedge clk); #1;
    ready = 1'b0; resp = 1'b0;
    @(negedge clk);
    chk_idle_outs("back_idle");
    chk("idle_lu", lu_data, exp_lu);
  endtask

  task automatic reset_mid_busy();
    @(posedge clk); #1;
    wr = 1'b1; addr = 32'h3000_0004; sz = 2'b10; rs2 = 32'hCAFE_F00D;
    ready = 1'b0;
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk);
    chk("rb_wr", {31'b0, dmwr}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rb_rq", {30'b0, dmrd, dmwr}, 32'd0);
    chk("rb_stall", {31'b0, stall}, 32'd0);
    chk("rb_addr", dmaddr, 32'd0);
    chk("rb_mask", {28'b0, mask}, 32'd0);
    chk("rb_data", dmdo, 32'd0);
    chk("rb_pulses", {29'b0, done, mis, flt}, 32'd0);
    chk("rb_lu", lu_data, 32'd0);
    exp_lu  = '0;
    exp_lsb = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outs("rb_after");
  endtask

  initial begin
    logic        r_rd, r_wr;
    logic [31:0] r_a;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; sz = '0;
    rs2 = '0; ready = 1'b0; resp = 1'b0; dmdi = '0;
    exp_lu = '0; exp_lsb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rq", {30'b0, dmrd, dmwr}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_pulses", {29'b0, done, mis, flt}, 32'd0);
    chk("rst_lu", lu_data, 32'd0);
    chk("rst_addr", dmaddr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    txn(1'b0, 1'b1, 32'h1000_0008, 2'b10, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    txn(1'b0, 1'b1, 32'h1000_0003, 2'b00, 32'h0000_00A5, 0, 1'b0, 32'h0);
    txn(1'b0, 1'b1, 32'h1000_0002, 2'b01, 32'h1111_BEEF, 1, 1'b0, 32'h0);
    txn(1'b1, 1'b0, 32'h1000_0002, 2'b01, 32'h0, 3, 1'b0, 32'h1234_5678);
    txn(1'b1, 1'b0, 32'h1000_0001, 2'b10, 32'h0, 0, 1'b0, 32'h0);
    txn(1'b1, 1'b0, 32'h1000_0003, 2'b01, 32'h0, 0, 1'b0, 32'h0);
    txn(1'b1, 1'b0, 32'h2000_0004, 2'b10, 32'h0, 1, 1'b1, 32'hBAD0_BAD0);
    txn(1'b0, 1'b1, 32'h2000_0000, 2'b11, 32'h5555_AAAA, 10, 1'b0, 32'h0);
    txn(1'b1, 1'b0, 32'h2000_0000, 2'b10, 32'h0, TO - 1, 1'b0, 32'h7777_0001);
    txn(1'b1, 1'b1, 32'h2000_0001, 2'b00, 32'h0000_003C, 0, 1'b0, 32'h0);
    reset_mid_busy();

    for (int n = 0; n < 300; n++) begin
      r_rd = 1'($urandom);
      r_wr = 1'($urandom);
      if (!r_rd && !r_wr) r_rd = 1'b1;
      r_a = $urandom;
      txn(r_rd, r_wr, r_a, 2'($urandom), $urandom,
          $urandom_range(0, TO + 1), ($urandom_range(0, 4) == 0),
          $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msrv32_dmem_access_ctrl.md
# msrv32_dmem_access_ctrl

Data-memory access controller for the msrv32 3-stage pipeline. It sits between the stage-2 address generation and the stage-3 load/writeback path. It turns a load/store request plus effective address into a held bus transaction with byte masks and aligned store data, and stalls the pipeline until the bus responds. It then hands captured read data and address LSBs to the load unit, and flags misaligned or faulted accesses.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: BUSY cycles without ready before access fault; 0 disables the timeout.

Ports:
- ms_riscv32_mp_clk_in  in  1  single clock, rising edge
- ms_riscv32_mp_rst_in  in  1  reset; asynchronous, active-high
- mem_rd_req_in  in  1  load request from stage 2
- mem_wr_req_in  in  1  store request from stage 2
- iadder_in  in  32  effective byte address
- access_size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
- rs2_in  in  32  store source data
- ms_riscv32_mp_dmaddr_out  out  32  word-aligned address {iadder[31:2],2'b00}
- ms_riscv32_mp_dmrd_req_out  out  1  bus read request
- ms_riscv32_mp_dmwr_req_out  out  1  bus write request
- ms_riscv32_mp_dmwr_mask_out  out  4  byte-lane write strobes
- ms_riscv32_mp_dmdata_out  out  32  lane-replicated store data
- ms_riscv32_mp_dmdata_in  in  32  bus read data, valid with ready
- ahb_ready_in  in  1  bus transfer complete
- ahb_resp_in  in  1  bus error, sampled only with ready
- lu_data_out  out  32  captured read word for the load unit
- lu_addr_lsb_out  out  2  captured iadder[1:0] for the load unit
- stall_out  out  1  hold pipeline stages 1-2
- done_out  out  1  one-cycle completion pulse
- misaligned_out  out  1  one-cycle misaligned-access pulse
- access_fault_out  out  1  one-cycle bus-error/timeout pulse

## Operation
- States: IDLE, BUSY, DONE, FAULT.
- IDLE with rd or wr asserted:
  - Misaligned access (half with addr[0]=1; word with addr[1:0]≠0) goes to FAULT with misaligned=1. No bus request is issued.
  - Otherwise the controller registers address, mask, data and direction, then goes to BUSY.
- rd and wr both asserted: the store wins and the load is ignored.
- BUSY: bus outputs are held stable.
  - ready=1 and resp=0: capture dmdata_in into lu_data_out (loads only; stores leave it unchanged) and go to DONE.
  - ready=1 and resp=1: go to FAULT with access_fault=1.
  - ready=0: the timeout counter increments. When it reaches TIMEOUT_CYCLES, go to FAULT with access_fault=1.
- DONE and FAULT last one cycle, then return to IDLE. New requests are not accepted in DONE or FAULT.
- Mask by size:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
  - Loads drive mask 0.
- Store data by size:
  - byte: {4{rs2[7:0]}}
  - half: {2{rs2[15:0]}}
  - word: rs2
- stall_out is combinational: (IDLE & (rd|wr)) | BUSY. It is 0 in DONE and FAULT, so the pipeline advances on that edge.

## Timing
- Reset values: state IDLE, all outputs 0, lu_data_out 0, counter 0.
- Reset mid-BUSY drops the bus request immediately (asynchronous) with no done/fault pulse.
- Minimum latency with zero-wait bus:
  - cycle 0: IDLE, request seen, stall=1
  - cycle 1: BUSY, ready=1, stall=1
  - cycle 2: DONE, done=1, stall=0
  - cycle 3: IDLE
- Each wait cycle adds one BUSY cycle.
- Timeout: fault is entered after exactly TIMEOUT_CYCLES consecutive ready=0 cycles in BUSY.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter clears on BUSY entry.
- ready in IDLE, DONE or FAULT is ignored.
- lu_data_out and lu_addr_lsb_out are stable from DONE until the next capture.

## Structure
- Package msrv32_dmem_pkg holds:
  - the state enum
  - the access-size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
- Sub-module msrv32_store_align is the combinational unit that computes mask, replicated data and misaligned flag from size, addr[1:0] and rs2.
- The FSM, timeout counter and capture registers live in the top module.

## Test plan
- Word store, addr 0x1000_0008, rs2 0xDEADBEEF, ready on first BUSY cycle -> dmaddr 0x1000_0008, mask 4'b1111, data 0xDEADBEEF, done at cycle 2, stall high cycles 0-1.
- Byte store, addr 0x...03, rs2 0x000000A5 -> mask 4'b1000, data 0xA5A5A5A5.
- Half load, addr 0x...02, three wait cycles, bus data 0x1234_5678 -> done at cycle 5, lu_data_out 0x12345678, lu_addr_lsb_out 2'b10.
- Word load at addr 0x...01 -> misaligned pulse at cycle 1, no rd/wr request ever asserted, stall low at cycle 1.
- Bus error (ready=1, resp=1) -> access_fault pulse, lu_data_out unchanged.
- TIMEOUT_CYCLES=4 with ready held 0 -> fault after 4 BUSY cycles.
- Reset asserted during BUSY -> all outputs 0 asynchronously, back to IDLE.
